// File: rtl/register_bank_pkg.sv
// -----------------------------------------------------------------------------
// register_bank_pkg
// Shared definitions for the register bank: the 4-bit operation code
// enumeration and the default bank geometry.
// -----------------------------------------------------------------------------
package register_bank_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREG  = 4;

    // Operation codes, applied to every enabled register.
    typedef enum logic [3:0] {
        FS_DEC   = 4'd0,   // Q - 1
        FS_INC   = 4'd1,   // Q + 1
        FS_LOAD  = 4'd2,   // I
        FS_CLR   = 4'd3,   // 0
        FS_LDB_Z = 4'd4,   // zero-extended I[7:0]
        FS_LDH_Z = 4'd5,   // zero-extended I[15:0]
        FS_SHL_B = 4'd6,   // {Q[W-9:0], I[7:0]}
        FS_LDH_S = 4'd7,   // sign-extended I[15:0]
        FS_LDB_S = 4'd8,   // sign-extended I[7:0]
        FS_ROL   = 4'd9,   // rotate left by 1
        FS_ROR   = 4'd10,  // rotate right by 1
        FS_LSR   = 4'd11,  // logical shift right by 1
        FS_LD_UP = 4'd12,  // {I[W/2-1:0], Q[W/2-1:0]}
        FS_ONES  = 4'd13,  // all ones
        FS_SWAP  = 4'd14,  // swap with (k+1) mod NREG
        FS_NOP   = 4'd15   // no operation
    } fun_sel_e;

endpackage : register_bank_pkg

// File: rtl/register_bank_cell.sv
// -----------------------------------------------------------------------------
// register_bank_cell
// One register of the bank together with its Zero and Carry flags.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears value and carry)
//   en         this register's enable
//   fun_sel    operation code (register_bank_pkg::fun_sel_e)
//   din        shared data input
//   swap_load  this cell takes swap_val during a swap operation
//   swap_val   value routed from the swap partner
//   q          current register value
//   zero       q == 0
//   carry      wrap / saturation / shifted-out flag
//
// Build option
//   REGISTER_BANK_SAT_EN  increment/decrement saturate instead of wrapping.
// -----------------------------------------------------------------------------
module register_bank_cell
    import register_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       fun_sel,
    input  logic [WIDTH-1:0] din,
    input  logic             swap_load,
    input  logic [WIDTH-1:0] swap_val,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             carry
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    fun_sel_e         op;
    logic [WIDTH-1:0] val_d, val_q;
    logic             carry_d, carry_q;

    assign op = fun_sel_e'(fun_sel);

    always_comb begin
        val_d   = val_q;
        carry_d = carry_q;
        if (op == FS_SWAP) begin
            // The partner cell may load a value without being enabled; only
            // enabled cells count as operated on and lose their carry.
            if (swap_load) begin
                val_d = swap_val;
            end
            if (en) begin
                carry_d = 1'b0;
            end
        end else if (en) begin
            carry_d = 1'b0;
            unique case (op)
                FS_DEC: begin
`ifdef REGISTER_BANK_SAT_EN
                    if (val_q == '0) begin
                        carry_d = 1'b1;
                    end else begin
                        val_d = val_q - ONE;
                    end
`else
                    val_d   = val_q - ONE;
                    carry_d = (val_q == '0);
`endif
                end
                FS_INC: begin
`ifdef REGISTER_BANK_SAT_EN
                    if (val_q == '1) begin
                        carry_d = 1'b1;
                    end else begin
                        val_d = val_q + ONE;
                    end
`else
                    val_d   = val_q + ONE;
                    carry_d = (val_q == '1);
`endif
                end
                FS_LOAD:  val_d = din;
                FS_CLR:   val_d = '0;
                FS_LDB_Z: val_d = WIDTH'(din[7:0]);
                FS_LDH_Z: val_d = WIDTH'(din[15:0]);
                FS_SHL_B: val_d = {val_q[WIDTH-9:0], din[7:0]};
                FS_LDH_S: val_d = WIDTH'($signed(din[15:0]));
                FS_LDB_S: val_d = WIDTH'($signed(din[7:0]));
                FS_ROL: begin
                    val_d   = {val_q[WIDTH-2:0], val_q[WIDTH-1]};
                    carry_d = val_q[WIDTH-1];
                end
                FS_ROR: begin
                    val_d   = {val_q[0], val_q[WIDTH-1:1]};
                    carry_d = val_q[0];
                end
                FS_LSR: begin
                    val_d   = {1'b0, val_q[WIDTH-1:1]};
                    carry_d = val_q[0];
                end
                FS_LD_UP: val_d = {din[WIDTH/2-1:0], val_q[WIDTH/2-1:0]};
                FS_ONES:  val_d = '1;
                FS_SWAP, FS_NOP: begin
                    val_d   = val_q;
                    carry_d = carry_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            val_q   <= val_d;
            carry_q <= carry_d;
        end
    end

    // Zero is decoded from the stored value so it tracks reset and swaps
    // without any extra state.
    assign q     = val_q;
    assign zero  = (val_q == '0);
    assign carry = carry_q;

endmodule : register_bank_cell

// File: rtl/register_bank.sv
// -----------------------------------------------------------------------------
// register_bank
// NREG registers of WIDTH bits sharing one operation code. Every enabled
// register applies FunSel to its own value; FunSel 14 swaps register k with
// its ring neighbour (k+1) mod NREG when only k is enabled. Two combinational
// read ports return 0 for selects beyond the last register.
//
// Ports
//   Clock             rising-edge clock
//   ResetN            asynchronous active-low reset
//   E[NREG]           per-register enable
//   FunSel[4]         operation code (register_bank_pkg::fun_sel_e)
//   I[WIDTH]          data input
//   OutASel, OutBSel  read-port selects
//   OutA, OutB        read-port data
//   Zero[NREG]        per-register zero flag
//   Carry[NREG]       per-register wrap/saturation/shift-out flag
//
// Build option
//   REGISTER_BANK_SAT_EN  increment/decrement saturate (implemented in
//                         register_bank_cell).
// -----------------------------------------------------------------------------
module register_bank
    import register_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREG  = DEF_NREG
) (
    input  logic                    Clock,
    input  logic                    ResetN,
    input  logic [NREG-1:0]         E,
    input  logic [3:0]              FunSel,
    input  logic [WIDTH-1:0]        I,
    input  logic [$clog2(NREG)-1:0] OutASel,
    input  logic [$clog2(NREG)-1:0] OutBSel,
    output logic [WIDTH-1:0]        OutA,
    output logic [WIDTH-1:0]        OutB,
    output logic [NREG-1:0]         Zero,
    output logic [NREG-1:0]         Carry
);

    localparam int SEL_W = $clog2(NREG);
    localparam int NTBL  = 1 << SEL_W;

    logic [WIDTH-1:0] cell_q   [NREG];
    logic [WIDTH-1:0] swap_val [NREG];
    logic [NREG-1:0]  swap_load;

    for (genvar k = 0; k < NREG; k++) begin : g_cell
        localparam int NXT = (k + 1) % NREG;
        localparam int PRV = (k + NREG - 1) % NREG;

        // A cell takes part in a swap either as the enabled initiator (its
        // next neighbour idle) or as the idle neighbour of an enabled
        // predecessor. Both cannot hold at once, so routing is unambiguous.
        assign swap_load[k] = (E[k] & ~E[NXT]) | (~E[k] & E[PRV]);
        assign swap_val[k]  = E[k] ? cell_q[NXT] : cell_q[PRV];

        register_bank_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk       (Clock),
            .rst_n     (ResetN),
            .en        (E[k]),
            .fun_sel   (FunSel),
            .din       (I),
            .swap_load (swap_load[k]),
            .swap_val  (swap_val[k]),
            .q         (cell_q[k]),
            .zero      (Zero[k]),
            .carry     (Carry[k])
        );
    end

    // Read table padded to the full select range; unused entries read 0.
    logic [WIDTH-1:0] rd_tbl [NTBL];

    for (genvar t = 0; t < NTBL; t++) begin : g_rd
        if (t < NREG) begin : g_live
            assign rd_tbl[t] = cell_q[t];
        end else begin : g_pad
            assign rd_tbl[t] = '0;
        end
    end

    assign OutA = rd_tbl[OutASel];
    assign OutB = rd_tbl[OutBSel];

endmodule : register_bank

// File: tb/tb_register_bank.sv
module tb_register_bank;

    localparam int     W   = 32;
    localparam int     N   = 4;
    localparam longint MOD = 64'sh1_0000_0000;

    logic         Clock   = 1'b0;
    logic         ResetN  = 1'b0;
    logic [N-1:0] E       = '0;
    logic [3:0]   FunSel  = 4'd15;
    logic [W-1:0] I       = '0;
    logic [1:0]   OutASel = 2'd0;
    logic [1:0]   OutBSel = 2'd0;
    logic [W-1:0] OutA, OutB;
    logic [N-1:0] Zero, Carry;

    register_bank #(.WIDTH(W), .NREG(N)) dut (
        .Clock   (Clock),
        .ResetN  (ResetN),
        .E       (E),
        .FunSel  (FunSel),
        .I       (I),
        .OutASel (OutASel),
        .OutBSel (OutBSel),
        .OutA    (OutA),
        .OutB    (OutB),
        .Zero    (Zero),
        .Carry   (Carry)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [N-1:0] z;
        logic [N-1:0] c;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] m_reg [N];
    logic [N-1:0] m_carry;
    int           n_tests = 0;
    int           n_fail  = 0;

    // ---------------- reference model ----------------
    function automatic void op_one(input logic [3:0] fs, input logic [W-1:0] v,
                                   input logic [W-1:0] din,
                                   output logic [W-1:0] nv, output logic nc);
        longint s;
        int     t;
        nv = v;
        nc = 1'b0;
        case (fs)
            4'd0: begin
                s  = longint'(v) - 1;
                nc = (s < 0);
`ifdef REGISTER_BANK_SAT_EN
                if (s < 0) s = 0;
`else
                if (s < 0) s = s + MOD;
`endif
                nv = s[W-1:0];
            end
            4'd1: begin
                s  = longint'(v) + 1;
                nc = (s >= MOD);
`ifdef REGISTER_BANK_SAT_EN
                if (s >= MOD) s = MOD - 1;
`else
                if (s >= MOD) s = s - MOD;
`endif
                nv = s[W-1:0];
            end
            4'd2:  nv = din;
            4'd3:  nv = 32'd0;
            4'd4:  nv = din % 256;
            4'd5:  nv = din % 65536;
            4'd6:  nv = (v * 256) + (din % 256);
            4'd7: begin
                t = int'(din % 65536);
                if (t >= 32768) t = t - 65536;
                nv = t;
            end
            4'd8: begin
                t = int'(din % 256);
                if (t >= 128) t = t - 256;
                nv = t;
            end
            4'd9:  begin nv = (v << 1) | (v >> 31); nc = (v >= 32'h8000_0000); end
            4'd10: begin nv = (v >> 1) | (v << 31); nc = (v % 2 == 1); end
            4'd11: begin nv = v / 2;                nc = (v % 2 == 1); end
            4'd12: nv = ((din % 65536) << 16) + (v % 65536);
            4'd13: nv = 32'hFFFF_FFFF;
            default: begin nv = v; nc = 1'b0; end
        endcase
    endfunction

    task automatic model_apply(input logic [N-1:0] e, input logic [3:0] fs,
                               input logic [W-1:0] din);
        logic [W-1:0] old [N];
        logic [W-1:0] nv;
        logic         nc;
        int           nxt;
        old = m_reg;
        for (int k = 0; k < N; k++) begin
            if (fs == 4'd14) begin
                nxt = (k + 1) % N;
                if (e[k]) begin
                    m_carry[k] = 1'b0;
                    if (!e[nxt]) begin
                        m_reg[k]   = old[nxt];
                        m_reg[nxt] = old[k];
                    end
                end
            end else if (fs != 4'd15 && e[k]) begin
                op_one(fs, old[k], din, nv, nc);
                m_reg[k]   = nv;
                m_carry[k] = nc;
            end
        end
    endtask

    task automatic push_expect(input logic [1:0] sa, input logic [1:0] sb);
        exp_t x;
        x.a = m_reg[sa];
        x.b = m_reg[sb];
        x.c = m_carry;
        for (int k = 0; k < N; k++) x.z[k] = (m_reg[k] == 0);
        sb_q.push_back(x);
    endtask

    // Drive one cycle: expectation is the state visible before the edge.
    task automatic step(input logic [N-1:0] e, input logic [3:0] fs,
                        input logic [W-1:0] din, input logic [1:0] sa,
                        input logic [1:0] sb);
        @(posedge Clock);
        #1;
        E = e; FunSel = fs; I = din; OutASel = sa; OutBSel = sb;
        push_expect(sa, sb);
        model_apply(e, fs, din);
    endtask

    // Reset asserted mid-cycle with an increment pending on every register.
    task automatic mid_reset();
        @(posedge Clock);
        #1;
        E = 4'b1111; FunSel = 4'd1; OutASel = 2'd0; OutBSel = 2'd3;
        #2;
        ResetN = 1'b0;
        for (int k = 0; k < N; k++) m_reg[k] = '0;
        m_carry = '0;
        push_expect(2'd0, 2'd3);
        @(negedge Clock);
        #2;
        ResetN = 1'b1;
        model_apply(E, FunSel, I);
    endtask

    // ---------------- monitor ----------------
    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(negedge Clock);
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                cmp("OutA",  OutA, x.a);
                cmp("OutB",  OutB, x.b);
                cmp("Zero",  W'(Zero), W'(x.z));
                cmp("Carry", W'(Carry), W'(x.c));
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [W-1:0] pick_data();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int wait_cnt;
        for (int k = 0; k < N; k++) m_reg[k] = '0;
        m_carry = '0;
        push_expect(2'd0, 2'd1);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        #2;
        ResetN = 1'b1;
        model_apply(E, FunSel, I);

        // wrap / saturate on R0
        step(4'b0001, 4'd2, 32'hFFFF_FFFF, 2'd0, 2'd0);
        step(4'b0001, 4'd1, 32'h0,         2'd0, 2'd0);
        step(4'b0001, 4'd3, 32'h0,         2'd0, 2'd0);
        step(4'b0000, 4'd15, 32'h0,        2'd0, 2'd0);
        // decrement from zero
        step(4'b0001, 4'd0, 32'h0,         2'd0, 2'd0);
        step(4'b0000, 4'd15, 32'h0,        2'd0, 2'd0);

        // swap R1/R2, then blocked swap
        step(4'b0010, 4'd2, 32'h11, 2'd1, 2'd2);
        step(4'b0100, 4'd2, 32'h22, 2'd1, 2'd2);
        step(4'b0010, 4'd14, 32'h0, 2'd1, 2'd2);
        step(4'b0110, 4'd14, 32'h0, 2'd1, 2'd2);
        step(4'b0000, 4'd15, 32'h0, 2'd1, 2'd2);
        // wrap-around swap R3 <-> R0
        step(4'b1000, 4'd14, 32'h0, 2'd3, 2'd0);

        // multi-enable rotate left
        step(4'b0001, 4'd2, 32'h5,         2'd0, 2'd3);
        step(4'b1000, 4'd2, 32'h8000_0000, 2'd0, 2'd3);
        step(4'b1001, 4'd9, 32'h0,         2'd0, 2'd3);
        step(4'b0000, 4'd15, 32'h0,        2'd0, 2'd3);

        // write-through-read timing on R1
        step(4'b0010, 4'd2, 32'hA5, 2'd1, 2'd1);
        step(4'b0000, 4'd15, 32'h0, 2'd1, 2'd1);

        // every register nonzero, then reset mid-cycle
        step(4'b1111, 4'd13, 32'h0, 2'd0, 2'd3);
        step(4'b0000, 4'd15, 32'h0, 2'd1, 2'd2);
        mid_reset();
        step(4'b0000, 4'd15, 32'h0, 2'd0, 2'd2);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(4'($urandom), 4'($urandom), pick_data(),
                 2'($urandom), 2'($urandom));
        end
        step(4'b0000, 4'd15, 32'h0, 2'd0, 2'd1);
        step(4'b0000, 4'd15, 32'h0, 2'd2, 2'd3);

        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 20) begin
            @(posedge Clock);
            wait_cnt++;
        end
        if (sb_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_register_bank
